// File: rtl/prefetch_queue_pkg.sv
// Shared types and sizing constants for the instruction prefetch queue.
// The optional starvation counter is enabled with PREFETCH_QUEUE_PERF_COUNTER_EN.
package prefetch_queue_pkg;

  localparam int PREFETCH_DEPTH  = 16;
  localparam int PREFETCH_WINDOW = 4;

  typedef logic [7:0]                          byte_t;
  typedef logic [$clog2(PREFETCH_DEPTH)-1:0]   ptr_t;
  typedef logic [$clog2(PREFETCH_DEPTH):0]     count_t;

endpackage

// File: rtl/prefetch_queue_if.sv
// Fill, window and consume signals between the bus unit, the queue and decode.
// o_starve_cycles exists only when PREFETCH_QUEUE_PERF_COUNTER_EN is defined.
interface prefetch_queue_if;
  import prefetch_queue_pkg::*;

  logic        i_flush;
  logic        i_fill_valid;
  logic        o_fill_ready;
  logic [31:0] i_fill_data;
  logic [1:0]  i_fill_skip;
  byte_t       o_window [PREFETCH_WINDOW];
  logic [2:0]  o_window_count;
  logic        i_consume_valid;
  logic [2:0]  i_consume_count;
  logic        o_empty;
  logic        o_error;
`ifdef PREFETCH_QUEUE_PERF_COUNTER_EN
  logic [31:0] o_starve_cycles;
`endif

  // Master drives fills/consumes (bus unit + decode); slave is the queue.
  modport master (
    output i_flush, i_fill_valid, i_fill_data, i_fill_skip, i_consume_valid, i_consume_count,
    input  o_fill_ready, o_window, o_window_count, o_empty, o_error
`ifdef PREFETCH_QUEUE_PERF_COUNTER_EN
    , input o_starve_cycles
`endif
  );

  modport slave (
    input  i_flush, i_fill_valid, i_fill_data, i_fill_skip, i_consume_valid, i_consume_count,
    output o_fill_ready, o_window, o_window_count, o_empty, o_error
`ifdef PREFETCH_QUEUE_PERF_COUNTER_EN
    , output o_starve_cycles
`endif
  );

endinterface

// File: rtl/prefetch_queue_storage.sv
// Circular byte store: 4-lane masked write at wr_ptr, 4-lane read at rd_ptr,
// both wrapping modulo DEPTH.
module prefetch_queue_storage
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic [3:0]    wr_en,
  input  logic [PW-1:0] wr_ptr,
  input  byte_t         wr_data [4],
  input  logic [PW-1:0] rd_ptr,
  output byte_t         rd_data [4]
);

  byte_t mem_q [DEPTH];

  // NOTE: the byte array is deliberately not reset; occupancy masks stale bytes.
  always_ff @(posedge clock) begin
    for (int j = 0; j < 4; j++) begin
      if (wr_en[j]) mem_q[wr_ptr + PW'(j)] <= wr_data[j];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_data[k] = mem_q[rd_ptr + PW'(k)];
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Byte-granular instruction prefetch queue feeding the prefix decoder.
// Optional starvation counter: define PREFETCH_QUEUE_PERF_COUNTER_EN.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH  = PREFETCH_DEPTH,
  parameter int WINDOW = PREFETCH_WINDOW
) (
  input  logic             clock,
  input  logic             reset,
  prefetch_queue_if.slave  pq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;

  logic [2:0]    win_count, fill_len;
  logic          fill_ready, fill_acc, consume_ok;
  logic [31:0]   fill_shifted;
  byte_t         fill_bytes [4];
  logic [3:0]    fill_mask;
  byte_t         rd_bytes [4];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    win_count    = (count_q >= CW'(WINDOW)) ? 3'(WINDOW) : count_q[2:0];
    fill_ready   = (count_q <= CW'(DEPTH - 4));
    fill_acc     = pq.i_fill_valid && fill_ready && !pq.i_flush;
    fill_len     = 3'd4 - {1'b0, pq.i_fill_skip};
    consume_ok   = pq.i_consume_valid && (pq.i_consume_count != 3'd0) &&
                   (pq.i_consume_count <= win_count);

    // Drop the skipped low bytes so lane 0 of the write is the first kept byte.
    fill_shifted = pq.i_fill_data >> {pq.i_fill_skip, 3'b000};
    for (int j = 0; j < 4; j++) begin
      fill_bytes[j] = fill_shifted[8*j +: 8];
      fill_mask[j]  = fill_acc && (3'(j) < fill_len);
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = 1'b0;
    if (pq.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fill_acc)   wr_ptr_d = wr_ptr_q + PW'(fill_len);
      if (consume_ok) rd_ptr_d = rd_ptr_q + PW'(pq.i_consume_count);
      count_d = count_q + (fill_acc ? CW'(fill_len) : CW'(0))
                        - (consume_ok ? CW'(pq.i_consume_count) : CW'(0));
      error_d = pq.i_consume_valid && !consume_ok;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  prefetch_queue_storage #(.DEPTH(DEPTH)) u_storage (
    .clock   (clock),
    .wr_en   (fill_mask),
    .wr_ptr  (wr_ptr_q),
    .wr_data (fill_bytes),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_bytes)
  );

  always_comb begin
    for (int k = 0; k < WINDOW; k++) begin
      pq.o_window[k] = (CW'(k) < count_q) ? rd_bytes[k] : 8'h00;
    end
  end

  assign pq.o_window_count = win_count;
  assign pq.o_empty        = (count_q == '0);
  assign pq.o_fill_ready   = fill_ready;
  assign pq.o_error        = error_q;

`ifdef PREFETCH_QUEUE_PERF_COUNTER_EN
  logic [31:0] starve_q, starve_d;

  // Decode is starved when the window is short and the bus offers nothing it could take.
  always_comb begin
    starve_d = starve_q;
    if ((win_count < 3'(WINDOW)) && fill_ready && !pq.i_fill_valid && (starve_q != '1))
      starve_d = starve_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign pq.o_starve_cycles = starve_q;
`endif

endmodule
